// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - RV32I/M/Zicsr opcode constants, immediate formats and decoded-control struct.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [2:0] F3_CSR_RSVD = 3'b100;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // Register/CSR addresses are already zeroed when the instruction does not use them.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] csr_addr;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        reg_wr_en;
    logic        csr_wr_en;
    logic        is_load;
    logic        illegal;
  } dec_ctrl_t;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
    imm_fmt_e fmt;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// rtl/decode_stage_comb.sv - pure combinational instruction decoder and operand selection.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int M_EXT  = 1,
  parameter int CSR_EN = 1
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] csr_data,
  output dec_ctrl_t       ctrl,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] op1_jump,
  output logic [XLEN-1:0] op2_jump,
  output logic [XLEN-1:0] reg1_data,
  output logic [XLEN-1:0] reg2_data,
  output logic [XLEN-1:0] csr_rd_data
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rs1f;
  logic [4:0]      rs2f;
  logic [4:0]      rdf;
  logic [XLEN-1:0] imm;
  logic            uses1;
  logic            uses2;
  logic            wr;
  logic            csr;
  logic            csr_we;
  logic            load;
  logic            ill;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign rs1f   = inst[19:15];
  assign rs2f   = inst[24:20];
  assign rdf    = inst[11:7];
  assign imm    = XLEN'($signed(imm_gen(inst, imm_fmt_of(opcode))));

  always_comb begin
    op1      = '0;
    op2      = '0;
    op1_jump = '0;
    op2_jump = '0;
    uses1    = 1'b0;
    uses2    = 1'b0;
    wr       = 1'b0;
    csr      = 1'b0;
    csr_we   = 1'b0;
    load     = 1'b0;
    ill      = 1'b0;
    case (opcode)
      OPC_LUI: begin
        op1 = imm;
        wr  = 1'b1;
      end
      OPC_AUIPC: begin
        op1 = imm;
        op2 = pc;
        wr  = 1'b1;
      end
      OPC_JAL: begin
        op1      = pc;
        op2      = XLEN'(4);
        op1_jump = pc;
        op2_jump = imm;
        wr       = 1'b1;
      end
      OPC_JALR: begin
        op1      = pc;
        op2      = XLEN'(4);
        op1_jump = rs1_data;
        op2_jump = imm;
        uses1    = 1'b1;
        wr       = 1'b1;
      end
      OPC_BRANCH: begin
        op1      = rs1_data;
        op2      = rs2_data;
        op1_jump = pc;
        op2_jump = imm;
        uses1    = 1'b1;
        uses2    = 1'b1;
        ill      = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        op1   = rs1_data;
        op2   = imm;
        uses1 = 1'b1;
        wr    = 1'b1;
        load  = 1'b1;
        ill   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        op1   = rs1_data;
        op2   = imm;
        uses1 = 1'b1;
        uses2 = 1'b1;
        ill   = f3[2] || (f3 == 3'b011);
      end
      OPC_OP_IMM: begin
        op1   = rs1_data;
        op2   = imm;
        uses1 = 1'b1;
        wr    = 1'b1;
        ill   = ((f3 == F3_SLL) && (f7 != F7_BASE)) ||
                ((f3 == F3_SR) && (f7 != F7_BASE) && (f7 != F7_ALT));
      end
      OPC_OP: begin
        op1   = rs1_data;
        op2   = rs2_data;
        uses1 = 1'b1;
        uses2 = 1'b1;
        wr    = 1'b1;
        case (f7)
          F7_BASE:   ill = 1'b0;
          F7_ALT:    ill = !((f3 == F3_ADD) || (f3 == F3_SR));
          F7_MULDIV: ill = (M_EXT == 0);
          default:   ill = 1'b1;
        endcase
      end
      OPC_FENCE: begin
        op1_jump = pc;
        op2_jump = XLEN'(4);
      end
      OPC_SYSTEM: begin
        if (f3 != F3_PRIV) begin
          csr = 1'b1;
          wr  = 1'b1;
          op2 = csr_data;
          // Set/clear with a zero source reads without writing the CSR.
          csr_we = (f3[1:0] == 2'b01) || (rs1f != 5'd0);
          if (f3[2]) begin
            op1 = XLEN'(rs1f);
          end else begin
            op1   = rs1_data;
            uses1 = 1'b1;
          end
          ill = (CSR_EN == 0) || (f3 == F3_CSR_RSVD);
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      uses1  = 1'b0;
      uses2  = 1'b0;
      wr     = 1'b0;
      csr    = 1'b0;
      csr_we = 1'b0;
      load   = 1'b0;
    end
  end

  always_comb begin
    ctrl           = '0;
    ctrl.uses_rs1  = uses1;
    ctrl.uses_rs2  = uses2;
    ctrl.rs1       = uses1 ? rs1f : 5'd0;
    ctrl.rs2       = uses2 ? rs2f : 5'd0;
    ctrl.reg_wr_en = wr && (rdf != 5'd0);
    ctrl.rd        = (wr && (rdf != 5'd0)) ? rdf : 5'd0;
    ctrl.csr_addr  = csr ? inst[31:20] : 12'd0;
    ctrl.csr_wr_en = csr_we;
    ctrl.is_load   = load;
    ctrl.illegal   = ill;
  end

  assign reg1_data   = uses1 ? rs1_data : '0;
  assign reg2_data   = uses2 ? rs2_data : '0;
  assign csr_rd_data = csr ? csr_data : '0;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with handshakes, load-use interlock and stall counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int M_EXT    = 1,
  parameter int CSR_EN   = 1,
  parameter int STALL_CW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [31:0]         inst_i,
  input  logic [XLEN-1:0]     inst_addr_i,
  output logic [4:0]          reg1_addr_o,
  output logic [4:0]          reg2_addr_o,
  input  logic [XLEN-1:0]     reg1_data_i,
  input  logic [XLEN-1:0]     reg2_data_i,
  output logic [11:0]         csr_rd_addr_o,
  input  logic [XLEN-1:0]     csr_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         inst_o,
  output logic [XLEN-1:0]     inst_addr_o,
  output logic [XLEN-1:0]     op1_o,
  output logic [XLEN-1:0]     op2_o,
  output logic [XLEN-1:0]     op1_jump_o,
  output logic [XLEN-1:0]     op2_jump_o,
  output logic [XLEN-1:0]     reg1_data_o,
  output logic [XLEN-1:0]     reg2_data_o,
  output logic [XLEN-1:0]     csr_rd_data_o,
  output logic                reg_wr_en_o,
  output logic [4:0]          reg_wr_addr_o,
  output logic                csr_wr_en_o,
  output logic [11:0]         csr_wr_addr_o,
  output logic                is_load_o,
  output logic                illegal_o,
  output logic [STALL_CW-1:0] stall_cnt_o
);

  dec_ctrl_t       ctrl;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] op1_jump;
  logic [XLEN-1:0] op2_jump;
  logic [XLEN-1:0] reg1_data;
  logic [XLEN-1:0] reg2_data;
  logic [XLEN-1:0] csr_rd_data;
  logic            hazard;
  logic            accept;

  decode_comb #(
    .XLEN   (XLEN),
    .M_EXT  (M_EXT),
    .CSR_EN (CSR_EN)
  ) u_comb (
    .inst        (inst_i),
    .pc          (inst_addr_i),
    .rs1_data    (reg1_data_i),
    .rs2_data    (reg2_data_i),
    .csr_data    (csr_data_i),
    .ctrl        (ctrl),
    .op1         (op1),
    .op2         (op2),
    .op1_jump    (op1_jump),
    .op2_jump    (op2_jump),
    .reg1_data   (reg1_data),
    .reg2_data   (reg2_data),
    .csr_rd_data (csr_rd_data)
  );

  assign reg1_addr_o   = ctrl.rs1;
  assign reg2_addr_o   = ctrl.rs2;
  assign csr_rd_addr_o = ctrl.csr_addr;

  // A held load whose result the incoming instruction reads must leave before we sample the RF.
  assign hazard = out_valid_o && is_load_o && (reg_wr_addr_o != 5'd0) &&
                  ((ctrl.uses_rs1 && (ctrl.rs1 == reg_wr_addr_o)) ||
                   (ctrl.uses_rs2 && (ctrl.rs2 == reg_wr_addr_o)));

  assign in_ready_o = !flush_i && !hazard && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o   <= 1'b0;
      inst_o        <= '0;
      inst_addr_o   <= '0;
      op1_o         <= '0;
      op2_o         <= '0;
      op1_jump_o    <= '0;
      op2_jump_o    <= '0;
      reg1_data_o   <= '0;
      reg2_data_o   <= '0;
      csr_rd_data_o <= '0;
      reg_wr_en_o   <= 1'b0;
      reg_wr_addr_o <= '0;
      csr_wr_en_o   <= 1'b0;
      csr_wr_addr_o <= '0;
      is_load_o     <= 1'b0;
      illegal_o     <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o   <= 1'b1;
      inst_o        <= inst_i;
      inst_addr_o   <= inst_addr_i;
      op1_o         <= op1;
      op2_o         <= op2;
      op1_jump_o    <= op1_jump;
      op2_jump_o    <= op2_jump;
      reg1_data_o   <= reg1_data;
      reg2_data_o   <= reg2_data;
      csr_rd_data_o <= csr_rd_data;
      reg_wr_en_o   <= ctrl.reg_wr_en;
      reg_wr_addr_o <= ctrl.rd;
      csr_wr_en_o   <= ctrl.csr_wr_en;
      csr_wr_addr_o <= ctrl.csr_addr;
      is_load_o     <= ctrl.is_load;
      illegal_o     <= ctrl.illegal;
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (in_valid_i && hazard && (stall_cnt_o != {STALL_CW{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + STALL_CW'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage (full and minimal configurations).
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  int          checks;
  int          failures;

  logic        in_ready, out_valid, reg_wr_en, csr_wr_en, is_load, illegal;
  logic [4:0]  reg1_addr, reg2_addr, reg_wr_addr;
  logic [11:0] csr_rd_addr, csr_wr_addr;
  logic [31:0] reg1_data, reg2_data, csr_data;
  logic [31:0] inst_q, inst_addr_q, op1, op2, op1_jump, op2_jump, reg1_q, reg2_q, csr_q;
  logic [31:0] stall_cnt;

  logic        in_ready_m, out_valid_m, reg_wr_en_m, csr_wr_en_m, is_load_m, illegal_m;
  logic [4:0]  reg1_addr_m, reg2_addr_m, reg_wr_addr_m;
  logic [11:0] csr_rd_addr_m, csr_wr_addr_m;
  logic [31:0] reg1_data_m, reg2_data_m, csr_data_m;
  logic [31:0] inst_q_m, inst_addr_q_m, op1_m, op2_m, op1_jump_m, op2_jump_m, reg1_q_m, reg2_q_m, csr_q_m;
  logic [1:0]  stall_cnt_m;

  // Register file model: x0 reads 0, xN reads 0x1000+N; CSR file reads 0xC0000000|addr.
  function automatic logic [31:0] rfv(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : 32'h1000 + 32'(a);
  endfunction

  assign reg1_data   = rfv(reg1_addr);
  assign reg2_data   = rfv(reg2_addr);
  assign csr_data    = 32'hC000_0000 | 32'(csr_rd_addr);
  assign reg1_data_m = rfv(reg1_addr_m);
  assign reg2_data_m = rfv(reg2_addr_m);
  assign csr_data_m  = 32'hC000_0000 | 32'(csr_rd_addr_m);

  decode_stage #(.XLEN(32), .M_EXT(1), .CSR_EN(1), .STALL_CW(32)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .inst_addr_i(inst_addr), .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
    .reg1_data_i(reg1_data), .reg2_data_i(reg2_data), .csr_rd_addr_o(csr_rd_addr), .csr_data_i(csr_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .inst_o(inst_q), .inst_addr_o(inst_addr_q),
    .op1_o(op1), .op2_o(op2), .op1_jump_o(op1_jump), .op2_jump_o(op2_jump),
    .reg1_data_o(reg1_q), .reg2_data_o(reg2_q), .csr_rd_data_o(csr_q),
    .reg_wr_en_o(reg_wr_en), .reg_wr_addr_o(reg_wr_addr), .csr_wr_en_o(csr_wr_en),
    .csr_wr_addr_o(csr_wr_addr), .is_load_o(is_load), .illegal_o(illegal), .stall_cnt_o(stall_cnt)
  );

  decode_stage #(.XLEN(32), .M_EXT(0), .CSR_EN(0), .STALL_CW(2)) u_dut_min (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_m),
    .inst_i(inst), .inst_addr_i(inst_addr), .reg1_addr_o(reg1_addr_m), .reg2_addr_o(reg2_addr_m),
    .reg1_data_i(reg1_data_m), .reg2_data_i(reg2_data_m), .csr_rd_addr_o(csr_rd_addr_m), .csr_data_i(csr_data_m),
    .out_valid_o(out_valid_m), .out_ready_i(out_ready), .inst_o(inst_q_m), .inst_addr_o(inst_addr_q_m),
    .op1_o(op1_m), .op2_o(op2_m), .op1_jump_o(op1_jump_m), .op2_jump_o(op2_jump_m),
    .reg1_data_o(reg1_q_m), .reg2_data_o(reg2_q_m), .csr_rd_data_o(csr_q_m),
    .reg_wr_en_o(reg_wr_en_m), .reg_wr_addr_o(reg_wr_addr_m), .csr_wr_en_o(csr_wr_en_m),
    .csr_wr_addr_o(csr_wr_addr_m), .is_load_o(is_load_m), .illegal_o(illegal_m), .stall_cnt_o(stall_cnt_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inst = 32'h0; inst_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
    checks++; if (op1 !== 32'h0 || inst_q !== 32'h0) begin failures++; $display("FAIL reset_fields got op1=%h inst=%h exp=0", op1, inst_q); end
    checks++; if (stall_cnt !== 32'h0) begin failures++; $display("FAIL reset_stall_cnt got=%h exp=0", stall_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%h exp=1", in_ready); end
  endtask

  task automatic test_addi();
    inst = 32'h0050_0093; inst_addr = 32'h100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%h exp=1", out_valid); end
    checks++; if (op2 !== 32'd5 || op1 !== 32'h0) begin failures++; $display("FAIL addi_ops got op1=%h op2=%h exp 0/5", op1, op2); end
    checks++; if (reg_wr_addr !== 5'd1 || reg_wr_en !== 1'b1) begin failures++; $display("FAIL addi_wr got addr=%h en=%h exp 1/1", reg_wr_addr, reg_wr_en); end
    checks++; if (illegal !== 1'b0 || inst_addr_q !== 32'h100) begin failures++; $display("FAIL addi_misc got ill=%h pc=%h exp 0/100", illegal, inst_addr_q); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL addi_drain got=%h exp=0", out_valid); end
  endtask

  task automatic test_load_use();
    inst = 32'h0001_2283; inst_addr = 32'h104; in_valid = 1'b1;
    step();
    checks++; if (is_load !== 1'b1 || reg_wr_addr !== 5'd5 || op1 !== 32'h1002) begin failures++; $display("FAIL lw_held got load=%h rd=%h op1=%h exp 1/5/1002", is_load, reg_wr_addr, op1); end
    inst = 32'h0012_8333; inst_addr = 32'h108;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_stall_ready got=%h exp=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 32'd1) begin failures++; $display("FAIL lu_bubble got valid=%h cnt=%h exp 0/1", out_valid, stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_ready_after got=%h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || inst_q !== 32'h0012_8333) begin failures++; $display("FAIL lu_add_accept got valid=%h inst=%h exp 1/00128333", out_valid, inst_q); end
    checks++; if (op1 !== 32'h1005 || op2 !== 32'h1001 || reg_wr_addr !== 5'd6) begin failures++; $display("FAIL lu_add_ops got %h %h %h exp 1005/1001/6", op1, op2, reg_wr_addr); end
    checks++; if (stall_cnt !== 32'd1 || stall_cnt_m !== 2'd1) begin failures++; $display("FAIL lu_cnt_final got %h %h exp 1/1", stall_cnt, stall_cnt_m); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    inst = 32'h0070_0113; inst_addr = 32'h10C; in_valid = 1'b1;
    step();
    inst = 32'h0050_0093; inst_addr = 32'h110;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_hs[%0d] got ready=%h valid=%h exp 0/1", i, in_ready, out_valid); end
      checks++; if (inst_q !== 32'h0070_0113 || op2 !== 32'd7 || reg_wr_addr !== 5'd2) begin failures++; $display("FAIL bp_hold_data[%0d] got %h %h %h exp 00700113/7/2", i, inst_q, op2, reg_wr_addr); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || inst_q !== 32'h0050_0093 || inst_addr_q !== 32'h110) begin failures++; $display("FAIL bp_next got %h %h %h exp 1/00500093/110", out_valid, inst_q, inst_addr_q); end
    step();
  endtask

  task automatic test_m_ext();
    inst = 32'h0220_81B3; inst_addr = 32'h114; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (illegal_m !== 1'b1 || reg_wr_en_m !== 1'b0) begin failures++; $display("FAIL mul_disabled got ill=%h en=%h exp 1/0", illegal_m, reg_wr_en_m); end
    checks++; if (illegal !== 1'b0 || reg_wr_addr !== 5'd3 || reg_wr_en !== 1'b1) begin failures++; $display("FAIL mul_enabled got ill=%h rd=%h en=%h exp 0/3/1", illegal, reg_wr_addr, reg_wr_en); end
    checks++; if (op1 !== 32'h1001 || op2 !== 32'h1002) begin failures++; $display("FAIL mul_ops got %h %h exp 1001/1002", op1, op2); end
    step();
  endtask

  task automatic test_csr();
    inst = 32'h3052_D3F3; inst_addr = 32'h118; in_valid = 1'b1;
    #1;
    checks++; if (csr_rd_addr !== 12'h305) begin failures++; $display("FAIL csr_rd_addr got=%h exp=305", csr_rd_addr); end
    step();
    in_valid = 1'b0;
    checks++; if (op1 !== 32'd5 || op2 !== 32'hC000_0305 || csr_q !== 32'hC000_0305) begin failures++; $display("FAIL csrrwi_ops got %h %h %h exp 5/C0000305/C0000305", op1, op2, csr_q); end
    checks++; if (csr_wr_en !== 1'b1 || csr_wr_addr !== 12'h305 || reg_wr_addr !== 5'd7) begin failures++; $display("FAIL csrrwi_wr got %h %h %h exp 1/305/7", csr_wr_en, csr_wr_addr, reg_wr_addr); end
    checks++; if (illegal_m !== 1'b1 || csr_wr_en_m !== 1'b0) begin failures++; $display("FAIL csr_disabled got ill=%h we=%h exp 1/0", illegal_m, csr_wr_en_m); end
    step();
  endtask

  task automatic test_branch();
    inst = 32'hFE20_8CE3; inst_addr = 32'h200; in_valid = 1'b1;
    #1;
    checks++; if (reg1_addr !== 5'd1 || reg2_addr !== 5'd2) begin failures++; $display("FAIL beq_rf_addr got %h %h exp 1/2", reg1_addr, reg2_addr); end
    step();
    in_valid = 1'b0;
    checks++; if (op1_jump !== 32'h200 || op2_jump !== 32'hFFFF_FFF8) begin failures++; $display("FAIL beq_jump got %h %h exp 200/FFFFFFF8", op1_jump, op2_jump); end
    checks++; if (reg_wr_en !== 1'b0 || op1 !== 32'h1001 || op2 !== 32'h1002) begin failures++; $display("FAIL beq_ops got en=%h %h %h exp 0/1001/1002", reg_wr_en, op1, op2); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    inst = 32'h0070_0113; inst_addr = 32'h204; in_valid = 1'b1;
    step();
    inst = 32'h0050_0093; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL flush_ready got ready=%h valid=%h exp 0/1", in_ready, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_kill got=%h exp=0", out_valid); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    inst = 32'h0001_2283; inst_addr = 32'h300; in_valid = 1'b1;
    step();
    inst = 32'h0012_8333; inst_addr = 32'h304;
    repeat (3) step();
    checks++; if (stall_cnt !== 32'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL stall_count got cnt=%h ready=%h valid=%h exp 4/0/1", stall_cnt, in_ready, out_valid); end
    checks++; if (stall_cnt_m !== 2'd3) begin failures++; $display("FAIL stall_saturate got=%h exp=3", stall_cnt_m); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || is_load !== 1'b0 || stall_cnt !== 32'h0) begin failures++; $display("FAIL async_reset_ctl got %h %h %h exp 0/0/0", out_valid, is_load, stall_cnt); end
    checks++; if (inst_q !== 32'h0 || op1 !== 32'h0 || reg_wr_addr !== 5'd0 || reg1_q !== 32'h0) begin failures++; $display("FAIL async_reset_data got %h %h %h %h exp 0", inst_q, op1, reg_wr_addr, reg1_q); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_addi();
    test_load_use();
    test_backpressure();
    test_m_ext();
    test_csr();
    test_branch();
    test_flush();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
